// File: rtl/jelly_video_tbl_demodulator.sv
// Table demodulator: rebuilds a multi-level image from 1-bit table-modulated
// frames. A per-pixel accumulator RAM sums the binary value over one modulation
// period. Every pixel leaves with its running count. The final-phase frame is
// flagged complete.
//
// Pipeline (advances only when cke = aclken & (~m_tvalid | m_tready)):
//   front : derive pixel address and phase of the incoming beat, issue RAM read
//   st0   : beat registered together with the RAM read data
//   st1   : saturating sum written back to RAM and presented on m_axi4s_*
//
// The phase counter is not an enumerated FSM. It is a modulo counter that
// restarts at 0 whenever phase >= end_reg at an SOF.
`timescale 1ns/1ps

module jelly_video_tbl_demodulator #(
    parameter int    TUSER_WIDTH = 1,
    parameter int    COUNT_WIDTH = 4,
    parameter int    PHASE_WIDTH = 4,
    parameter int    ADDR_WIDTH  = 14,
    parameter string RAM_TYPE    = "block"
) (
    input  logic                   aresetn,
    input  logic                   aclk,
    input  logic                   aclken,

    input  logic [PHASE_WIDTH-1:0] param_end,
    input  logic                   param_inv,

    input  logic [TUSER_WIDTH-1:0] s_axi4s_tuser,
    input  logic                   s_axi4s_tlast,
    input  logic                   s_axi4s_tbinary,
    input  logic                   s_axi4s_tvalid,
    output logic                   s_axi4s_tready,

    output logic [TUSER_WIDTH-1:0] m_axi4s_tuser,
    output logic                   m_axi4s_tlast,
    output logic [COUNT_WIDTH-1:0] m_axi4s_tdata,
    output logic                   m_axi4s_tcomplete,
    output logic                   m_axi4s_tvalid,
    input  logic                   m_axi4s_tready
);

    localparam int                     RAM_DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0]  ADDR_MAX  = {ADDR_WIDTH{1'b1}};
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = {COUNT_WIDTH{1'b1}};

    // frame-level state
    logic [PHASE_WIDTH-1:0] phase_q, phase_d;
    logic [PHASE_WIDTH-1:0] end_q,   end_d;
    logic                   inv_q,   inv_d;
    logic [ADDR_WIDTH-1:0]  addr_q,  addr_d;

    // st0 registers
    logic                   st0_valid_q,    st0_valid_d;
    logic [TUSER_WIDTH-1:0] st0_user_q,     st0_user_d;
    logic                   st0_last_q,     st0_last_d;
    logic                   st0_bit_q,      st0_bit_d;
    logic                   st0_clear_q,    st0_clear_d;
    logic                   st0_complete_q, st0_complete_d;
    logic [ADDR_WIDTH-1:0]  st0_addr_q,     st0_addr_d;
    logic                   byp_q,          byp_d;
    logic [COUNT_WIDTH-1:0] byp_data_q,     byp_data_d;

    // st1 / output registers
    logic                   m_valid_q,    m_valid_d;
    logic [TUSER_WIDTH-1:0] m_user_q,     m_user_d;
    logic                   m_last_q,     m_last_d;
    logic [COUNT_WIDTH-1:0] m_data_q,     m_data_d;
    logic                   m_complete_q, m_complete_d;

    // accumulator RAM and its read register
    (* ram_style = RAM_TYPE *)
    logic [COUNT_WIDTH-1:0] acc_ram [0:RAM_DEPTH-1];
    logic [COUNT_WIDTH-1:0] ram_rd_q;

    logic                   cke;
    logic                   s_sof;
    logic                   s_accept;
    logic [PHASE_WIDTH-1:0] beat_phase;
    logic [PHASE_WIDTH-1:0] beat_end;
    logic                   beat_inv;
    logic [ADDR_WIDTH-1:0]  beat_addr;
    logic [COUNT_WIDTH-1:0] rd_data;
    logic [COUNT_WIDTH-1:0] acc_base;
    logic [COUNT_WIDTH-1:0] sum;
    logic                   wr_en;

    assign cke            = aclken & (~m_valid_q | m_axi4s_tready);
    assign s_axi4s_tready = ~m_valid_q | m_axi4s_tready;
    assign s_sof          = s_axi4s_tuser[0];
    assign s_accept       = cke & s_axi4s_tvalid;
    assign wr_en          = cke & st0_valid_q;

    // Phase and address of the incoming beat, plus the frame-level state update.
    always_comb begin
        beat_phase = phase_q;
        beat_end   = end_q;
        beat_inv   = inv_q;
        beat_addr  = addr_q;
        if (s_sof) begin
            // ">=" also recovers when a shorter period was latched below the running phase
            beat_phase = (phase_q >= end_q) ? '0 : phase_q + 1'b1;
            beat_end   = param_end;
            beat_inv   = param_inv;
            beat_addr  = '0;
        end

        phase_d = phase_q;
        end_d   = end_q;
        inv_d   = inv_q;
        addr_d  = addr_q;
        if (s_accept) begin
            phase_d = beat_phase;
            end_d   = beat_end;
            inv_d   = beat_inv;
            addr_d  = (beat_addr == ADDR_MAX) ? ADDR_MAX : beat_addr + 1'b1;
        end
    end

    // Saturating accumulate for the beat held in st0. Phase 0 ignores stale RAM content.
    always_comb begin
        rd_data  = byp_q ? byp_data_q : ram_rd_q;
        acc_base = st0_clear_q ? '0 : rd_data;
        if (acc_base == COUNT_MAX) begin
            sum = COUNT_MAX;
        end else begin
            sum = acc_base + {{(COUNT_WIDTH-1){1'b0}}, st0_bit_q};
        end
    end

    // st0 load. Bypass covers only saturated aliasing, where st1 writes the address st0 reads.
    always_comb begin
        st0_valid_d    = st0_valid_q;
        st0_user_d     = st0_user_q;
        st0_last_d     = st0_last_q;
        st0_bit_d      = st0_bit_q;
        st0_clear_d    = st0_clear_q;
        st0_complete_d = st0_complete_q;
        st0_addr_d     = st0_addr_q;
        byp_d          = byp_q;
        byp_data_d     = byp_data_q;
        if (cke) begin
            st0_valid_d    = s_axi4s_tvalid;
            st0_user_d     = s_axi4s_tuser;
            st0_last_d     = s_axi4s_tlast;
            st0_bit_d      = s_axi4s_tbinary ^ beat_inv;
            st0_clear_d    = (beat_phase == '0);
            st0_complete_d = (beat_phase == beat_end);
            st0_addr_d     = beat_addr;
            byp_d          = wr_en && (st0_addr_q == beat_addr);
            byp_data_d     = sum;
        end
    end

    // st1 load: present the accumulated count.
    always_comb begin
        m_valid_d    = m_valid_q;
        m_user_d     = m_user_q;
        m_last_d     = m_last_q;
        m_data_d     = m_data_q;
        m_complete_d = m_complete_q;
        if (cke) begin
            m_valid_d    = st0_valid_q;
            m_user_d     = st0_user_q;
            m_last_d     = st0_last_q;
            m_data_d     = sum;
            m_complete_d = st0_complete_q;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            phase_q        <= '0;
            end_q          <= '0;
            inv_q          <= 1'b0;
            addr_q         <= '0;
            st0_valid_q    <= 1'b0;
            st0_user_q     <= '0;
            st0_last_q     <= 1'b0;
            st0_bit_q      <= 1'b0;
            st0_clear_q    <= 1'b0;
            st0_complete_q <= 1'b0;
            st0_addr_q     <= '0;
            byp_q          <= 1'b0;
            byp_data_q     <= '0;
            m_valid_q      <= 1'b0;
            m_user_q       <= '0;
            m_last_q       <= 1'b0;
            m_data_q       <= '0;
            m_complete_q   <= 1'b0;
        end else begin
            phase_q        <= phase_d;
            end_q          <= end_d;
            inv_q          <= inv_d;
            addr_q         <= addr_d;
            st0_valid_q    <= st0_valid_d;
            st0_user_q     <= st0_user_d;
            st0_last_q     <= st0_last_d;
            st0_bit_q      <= st0_bit_d;
            st0_clear_q    <= st0_clear_d;
            st0_complete_q <= st0_complete_d;
            st0_addr_q     <= st0_addr_d;
            byp_q          <= byp_d;
            byp_data_q     <= byp_data_d;
            m_valid_q      <= m_valid_d;
            m_user_q       <= m_user_d;
            m_last_q       <= m_last_d;
            m_data_q       <= m_data_d;
            m_complete_q   <= m_complete_d;
        end
    end

    // Accumulator RAM: read-first, registered read, no reset so it maps onto block RAM.
    always_ff @(posedge aclk) begin
        if (wr_en) begin
            acc_ram[st0_addr_q] <= sum;
        end
        if (cke) begin
            ram_rd_q <= acc_ram[beat_addr];
        end
    end

    assign m_axi4s_tvalid    = m_valid_q;
    assign m_axi4s_tuser     = m_user_q;
    assign m_axi4s_tlast     = m_last_q;
    assign m_axi4s_tdata     = m_data_q;
    assign m_axi4s_tcomplete = m_complete_q;

endmodule
